jtopl_pg_fnum_enc: RTL and testbench
====================================

Name: jtopl_pg_fnum_enc

Overview:
Inverse of the phase-generator increment path: converts a target 17-bit pure phase increment into the OPL block/fnum register pair (phinc = fnum << block).
- Used by the test/host-side helper logic and by pitch-tracking features that compute a frequency and must write it back as OPL registers.
- Multi-cycle normaliser: one right-shift per cycle, with valid/ready handshakes on both sides.

Parameters:
ROUND, 0, 0 = truncate dropped bits; 1 = round half-up using the last dropped bit.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- cen  in  1  clock enable; state, handshakes and outputs advance only when cen=1
- phinc  in  17  target pure phase increment (unsigned)
- in_valid  in  1  phinc is valid
- in_ready  out  1  block can accept a request (high only in IDLE)
- block  out  3  encoded block
- fnum  out  10  encoded fnum
- inexact  out  1  at least one nonzero bit was dropped
- sat  out  1  rounding overflowed at block 7; fnum clamped
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result

Behaviour:
- Reset (async, rst_n=0): state=IDLE; block=0, fnum=0, inexact=0, sat=0, out_valid=0. in_ready=1 once reset is released.
- All sequential updates are qualified by cen. When cen=0, every register holds; a handshake only completes on a cycle with cen=1.
- Internal registers: val[16:0], blk[2:0], guard, sticky.
- IDLE: in_ready=1. On in_valid & cen: val<=phinc, blk<=0, guard<=0, sticky<=0; go to SHIFT.
- SHIFT, when val[16:10]!=0:
  - val<=val>>1; blk<=blk+1; guard<=val[0]; sticky<=sticky|guard.
  - At most 7 shifts; phinc max 131071 always fits by blk=7.
- SHIFT, when val[16:10]==0 (finish, same cycle):
  - Compute r = val[9:0] + (ROUND & guard), 11 bits.
  - If r==1024 and blk<7: fnum<=512, block<=blk+1, sat<=0.
  - If r==1024 and blk==7: fnum<=1023, block<=7, sat<=1.
  - Otherwise: fnum<=r[9:0], block<=blk, sat<=0.
  - inexact <= guard|sticky, regardless of ROUND.
  - out_valid<=1; go to DONE.
- Latency: out_valid rises N+1 enabled cycles after the accepting edge, where N is the number of shifts (0..7).
- DONE: outputs are held stable while out_ready=0. On out_ready & cen: out_valid<=0, go to IDLE. in_ready is low in DONE, so there is no same-cycle re-accept; throughput is one request per N+3 enabled cycles.
- block/fnum/inexact/sat are updated only at finish. They keep their last values after the handshake until the next result.
- Reset asserted mid-operation aborts immediately to the reset values; no partial result is ever flagged valid.
- phinc=0 gives block=0, fnum=0, inexact=0 with latency 1.
- Round-trip property: fnum << block equals phinc when inexact=0 and sat=0.

Decomposition:
- Shared package/include: state encodings (IDLE, SHIFT, DONE), PHINC_W=17, FNUM_W=10, BLK_W=3.
- A small combinational sub-module jtopl_pg_fnum_rnd handles finish-cycle rounding, block bump and saturation. Inputs: val[9:0], blk, guard, ROUND. Outputs: block, fnum, sat.
- The FSM and shifter stay in the top module.

Test Plan:
- phinc=341, cen=1, out_ready=1 -> block=0, fnum=341, inexact=0, out_valid 1 cycle after accept.
- phinc=65536 -> block=7, fnum=512, inexact=0, latency 8 cycles; also verify 1023<<3=8184 -> block=3, fnum=1023.
- ROUND=1, phinc=2047 -> block=2, fnum=512, inexact=1, sat=0. With ROUND=0, same input -> block=1, fnum=1023, inexact=1.
- ROUND=1, phinc=131071 -> block=7, fnum=1023, sat=1, inexact=1.
- Handshake/cen:
  - Hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0.
  - Toggle cen every other cycle -> latency doubles exactly in clk cycles.
  - Back-to-back requests -> each result is correct.
- Assert rst_n low during SHIFT (phinc=65536, 3rd shift) -> out_valid=0 and all outputs 0 immediately. After release, a new phinc=341 is encoded correctly.

Source files
------------

// File: rtl/jtopl_pg_fnum_enc_pkg.sv
// Shared types and widths for the phase-increment to block/fnum encoder.
package jtopl_pg_fnum_enc_pkg;

    localparam int unsigned PHINC_W = 17;
    localparam int unsigned FNUM_W  = 10;
    localparam int unsigned BLK_W   = 3;
    localparam int unsigned R_W     = FNUM_W + 1;

    localparam logic [R_W-1:0]    FNUM_OVF  = {1'b1, {FNUM_W{1'b0}}};
    localparam logic [FNUM_W-1:0] FNUM_HALF = {1'b1, {(FNUM_W-1){1'b0}}};
    localparam logic [FNUM_W-1:0] FNUM_MAX  = {FNUM_W{1'b1}};
    localparam logic [BLK_W-1:0]  BLK_MAX   = {BLK_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/jtopl_pg_fnum_enc_if.sv
// Request/result handshake bundle between a host and the encoder.
interface jtopl_pg_fnum_enc_if;
    import jtopl_pg_fnum_enc_pkg::*;

    logic [PHINC_W-1:0] phinc;
    logic               in_valid;
    logic               in_ready;
    logic [BLK_W-1:0]   block;
    logic [FNUM_W-1:0]  fnum;
    logic               inexact;
    logic               sat;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output phinc, in_valid, out_ready,
        input  in_ready, block, fnum, inexact, sat, out_valid
    );

    modport slave (
        input  phinc, in_valid, out_ready,
        output in_ready, block, fnum, inexact, sat, out_valid
    );

endinterface

// File: rtl/jtopl_pg_fnum_rnd.sv
// Finish-cycle rounding: applies the guard bit, bumps the block on fnum overflow,
// and clamps at the top block.
module jtopl_pg_fnum_rnd
    import jtopl_pg_fnum_enc_pkg::*;
#(
    parameter int unsigned ROUND = 0
) (
    input  logic [FNUM_W-1:0] val,
    input  logic [BLK_W-1:0]  blk,
    input  logic              guard,
    output logic [BLK_W-1:0]  block,
    output logic [FNUM_W-1:0] fnum,
    output logic              sat
);

    logic [R_W-1:0] r;

    // Round half-up (optional) and renormalise a carry out of the fnum field
    always_comb begin
        r     = {1'b0, val} + R_W'(guard & 1'(ROUND));
        block = blk;
        fnum  = r[FNUM_W-1:0];
        sat   = 1'b0;
        if (r == FNUM_OVF) begin
            if (blk != BLK_MAX) begin
                block = blk + BLK_W'(1);
                fnum  = FNUM_HALF;
            end else begin
                fnum  = FNUM_MAX;
                sat   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/jtopl_pg_fnum_enc.sv
// Multi-cycle normaliser turning a pure phase increment into OPL block/fnum.
module jtopl_pg_fnum_enc
    import jtopl_pg_fnum_enc_pkg::*;
#(
    parameter int unsigned ROUND = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cen,
    jtopl_pg_fnum_enc_if.slave   bus
);

    state_t             state, state_nx;
    logic [PHINC_W-1:0] val, val_nx;
    logic [BLK_W-1:0]   blk, blk_nx;
    logic               guard, guard_nx;
    logic               sticky, sticky_nx;

    logic [BLK_W-1:0]   block_q, block_nx;
    logic [FNUM_W-1:0]  fnum_q, fnum_nx;
    logic               inexact_q, inexact_nx;
    logic               sat_q, sat_nx;
    logic               out_valid_q, out_valid_nx;
    logic               in_ready_q;

    logic [BLK_W-1:0]   rnd_block;
    logic [FNUM_W-1:0]  rnd_fnum;
    logic               rnd_sat;

    jtopl_pg_fnum_rnd #(.ROUND(ROUND)) u_rnd (
        .val   (val[FNUM_W-1:0]),
        .blk   (blk),
        .guard (guard),
        .block (rnd_block),
        .fnum  (rnd_fnum),
        .sat   (rnd_sat)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else if (cen) begin
            state <= state_nx;
        end
    end

    // Next-state, shifter and result capture
    always_comb begin
        state_nx     = state;
        val_nx       = val;
        blk_nx       = blk;
        guard_nx     = guard;
        sticky_nx    = sticky;
        block_nx     = block_q;
        fnum_nx      = fnum_q;
        inexact_nx   = inexact_q;
        sat_nx       = sat_q;
        out_valid_nx = out_valid_q;
        case (state)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    val_nx    = bus.phinc;
                    blk_nx    = '0;
                    guard_nx  = 1'b0;
                    sticky_nx = 1'b0;
                    state_nx  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (val[PHINC_W-1:FNUM_W] != '0) begin
                    val_nx    = val >> 1;
                    blk_nx    = blk + BLK_W'(1);
                    guard_nx  = val[0];
                    sticky_nx = sticky | guard;
                end else begin
                    block_nx     = rnd_block;
                    fnum_nx      = rnd_fnum;
                    sat_nx       = rnd_sat;
                    inexact_nx   = guard | sticky;
                    out_valid_nx = 1'b1;
                    state_nx     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    out_valid_nx = 1'b0;
                    state_nx     = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val         <= '0;
            blk         <= '0;
            guard       <= 1'b0;
            sticky      <= 1'b0;
            block_q     <= '0;
            fnum_q      <= '0;
            inexact_q   <= 1'b0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else if (cen) begin
            val         <= val_nx;
            blk         <= blk_nx;
            guard       <= guard_nx;
            sticky      <= sticky_nx;
            block_q     <= block_nx;
            fnum_q      <= fnum_nx;
            inexact_q   <= inexact_nx;
            sat_q       <= sat_nx;
            out_valid_q <= out_valid_nx;
            in_ready_q  <= (state_nx == ST_IDLE);
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.block     = block_q;
    assign bus.fnum      = fnum_q;
    assign bus.inexact   = inexact_q;
    assign bus.sat       = sat_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_jtopl_pg_fnum_enc.sv
// Bench for the block/fnum encoder: truncating and rounding instances run in lockstep.
module tb_jtopl_pg_fnum_enc;

    logic clk = 1'b0;
    logic rst_n;
    logic cen;

    int n_checks = 0;
    int n_err    = 0;

    jtopl_pg_fnum_enc_if bus0 ();
    jtopl_pg_fnum_enc_if bus1 ();

    jtopl_pg_fnum_enc #(.ROUND(0)) dut0 (.clk(clk), .rst_n(rst_n), .cen(cen), .bus(bus0));
    jtopl_pg_fnum_enc #(.ROUND(1)) dut1 (.clk(clk), .rst_n(rst_n), .cen(cen), .bus(bus1));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: smallest block that fits fnum in 10 bits, then optional round-up
    task automatic model(input int p, input bit rnd, output int b, output int f,
                         output bit inx, output bit st, output int lat);
        b = 0;
        while ((p >> b) >= 1024) b++;
        lat = b + 1;
        f   = p >> b;
        inx = (b > 0) && ((p & ((1 << b) - 1)) != 0);
        if (rnd && b > 0 && (((p >> (b - 1)) & 1) == 1)) f++;
        st = 1'b0;
        if (f == 1024) begin
            if (b < 7) begin
                b++;
                f = 512;
            end else begin
                f  = 1023;
                st = 1'b1;
            end
        end
    endtask

    task automatic drive(input logic [16:0] p, input logic iv, input logic ordy);
        bus0.phinc = p;   bus1.phinc = p;
        bus0.in_valid = iv; bus1.in_valid = iv;
        bus0.out_ready = ordy; bus1.out_ready = ordy;
    endtask

    task automatic do_req(input string tag, input int p, input bit toggle, input int hold);
        int b0, f0, l0, b1, f1, l1, cyc;
        bit x0, s0, x1, s1, done;
        model(p, 1'b0, b0, f0, x0, s0, l0);
        model(p, 1'b1, b1, f1, x1, s1, l1);
        chk({tag, ".in_ready"}, int'(bus0.in_ready & bus1.in_ready), 1);
        cen = 1'b1;
        drive(17'(p), 1'b1, 1'b0);
        @(negedge clk);
        drive(17'(p), 1'b0, 1'b0);
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 64) begin
            cen = !toggle || (((cyc + 1) % 2) == 0);
            @(negedge clk);
            cyc++;
            if (bus0.out_valid) done = 1'b1;
        end
        cen = 1'b1;
        chk({tag, ".latency"}, cyc, toggle ? 2 * l0 : l0);
        chk({tag, ".valid1"}, int'(bus1.out_valid), 1);
        chk({tag, ".r0.block"}, int'(bus0.block), b0);
        chk({tag, ".r0.fnum"}, int'(bus0.fnum), f0);
        chk({tag, ".r0.inexact"}, int'(bus0.inexact), int'(x0));
        chk({tag, ".r0.sat"}, int'(bus0.sat), int'(s0));
        chk({tag, ".r1.block"}, int'(bus1.block), b1);
        chk({tag, ".r1.fnum"}, int'(bus1.fnum), f1);
        chk({tag, ".r1.inexact"}, int'(bus1.inexact), int'(x1));
        chk({tag, ".r1.sat"}, int'(bus1.sat), int'(s1));
        if (!s0 && !x0) chk({tag, ".roundtrip"}, int'(bus0.fnum) << bus0.block, p);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, ".hold.valid"}, int'(bus0.out_valid & bus1.out_valid), 1);
            chk({tag, ".hold.in_ready"}, int'(bus0.in_ready | bus1.in_ready), 0);
            chk({tag, ".hold.r0"}, int'({bus0.block, bus0.fnum, bus0.inexact, bus0.sat}),
                (b0 << 12) | (f0 << 2) | (int'(x0) << 1) | int'(s0));
            chk({tag, ".hold.r1"}, int'({bus1.block, bus1.fnum, bus1.inexact, bus1.sat}),
                (b1 << 12) | (f1 << 2) | (int'(x1) << 1) | int'(s1));
        end
        drive(17'(p), 1'b0, 1'b1);
        @(negedge clk);
        drive(17'(p), 1'b0, 1'b0);
        chk({tag, ".ack.valid"}, int'(bus0.out_valid | bus1.out_valid), 0);
        chk({tag, ".ack.in_ready"}, int'(bus0.in_ready & bus1.in_ready), 1);
        chk({tag, ".ack.keep"}, int'({bus0.block, bus0.fnum}), (b0 << 10) | f0);
    endtask

    initial begin
        rst_n = 1'b0;
        cen   = 1'b1;
        drive(17'd0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst.out", int'({bus0.block, bus0.fnum, bus0.inexact, bus0.sat, bus0.out_valid}), 0);
        chk("rst.out1", int'({bus1.block, bus1.fnum, bus1.inexact, bus1.sat, bus1.out_valid}), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst.in_ready", int'(bus0.in_ready & bus1.in_ready), 1);

        do_req("p341", 341, 1'b0, 0);
        do_req("p65536", 65536, 1'b0, 0);
        do_req("p8184", 8184, 1'b0, 0);
        do_req("p2047", 2047, 1'b0, 0);
        do_req("p131071", 131071, 1'b0, 0);
        do_req("p0", 0, 1'b0, 0);
        do_req("hold5", 5000, 1'b0, 5);
        do_req("cen341", 341, 1'b1, 0);
        do_req("cen65536", 65536, 1'b1, 2);
        do_req("b2b_a", 1023, 1'b0, 0);
        do_req("b2b_b", 1024, 1'b0, 0);
        do_req("b2b_c", 99999, 1'b0, 0);

        for (int k = 0; k < 24; k++) begin
            int sh, pr;
            sh = $urandom_range(0, 17);
            pr = int'($urandom) & ((1 << sh) - 1);
            do_req("rand", pr, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end

        // Abort in the middle of the shift sequence
        cen = 1'b1;
        drive(17'd65536, 1'b1, 1'b0);
        @(negedge clk);
        drive(17'd65536, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort.out", int'({bus0.block, bus0.fnum, bus0.inexact, bus0.sat, bus0.out_valid}), 0);
        chk("abort.out1", int'({bus1.block, bus1.fnum, bus1.inexact, bus1.sat, bus1.out_valid}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("abort.novalid", int'(bus0.out_valid | bus1.out_valid), 0);
        do_req("post_rst", 341, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
